// File: rtl/led_pkg.sv
// Shared types and default constants for the LED fade PWM output stage.
package led_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RISE = 2'd1,
      ON   = 2'd2,
      FALL = 2'd3
   } fade_state_t;

   localparam int LED_PWM_BITS    = 8;
   localparam int LED_STEP_CYCLES = 105468;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator; the compare value is only taken at the period
// boundary so a duty update never distorts the period in flight.
module pwm_gen
   import led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] cmp_in,
   input  logic                force_on,
   output logic                pwm_out
);

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] cmp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
         cmp     <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == CNT_MAX) begin
            cmp <= cmp_in;
         end
         pwm_out <= force_on | (pwm_cnt < cmp);
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// Soft-blink LED driver: ramps PWM duty linearly on each led_in level change.
// Optional square-law duty curve enabled by defining LED_FADE_GAMMA_EN.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int PWM_BITS    = LED_PWM_BITS,
   parameter int STEP_CYCLES = LED_STEP_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                led_in,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] duty,
   output logic                busy
);

   localparam int                  STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

   fade_state_t         state, state_nxt;
   logic [PWM_BITS-1:0] duty_nxt;
   logic [STEP_W-1:0]   step_cnt, step_nxt;
   logic                ramping;
   logic                strobe;
   logic [PWM_BITS-1:0] cmp_in;

   function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
      return (v == DUTY_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   assign ramping = (state == RISE) || (state == FALL);
   assign strobe  = ramping && (step_cnt == STEP_LAST);

   // A reversal takes priority over a coincident step, so the step is dropped.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      case (state)
         OFF:  if (led_in) state_nxt = RISE;
         RISE: begin
            if (!led_in) begin
               state_nxt = FALL;
            end else if (strobe) begin
               duty_nxt = sat_inc(duty);
               if (duty >= DUTY_MAX - 1'b1) state_nxt = ON;
            end
         end
         ON:   if (!led_in) state_nxt = FALL;
         FALL: begin
            if (led_in) begin
               state_nxt = RISE;
            end else if (strobe) begin
               duty_nxt = sat_dec(duty);
               if (duty <= DUTY_ONE) state_nxt = OFF;
            end
         end
         default: state_nxt = OFF;
      endcase

      step_nxt = '0;
      if (ramping && (state_nxt == state) && !strobe) begin
         step_nxt = step_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= OFF;
         duty     <= '0;
         step_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         duty     <= duty_nxt;
         step_cnt <= step_nxt;
         busy     <= ramping;
      end
   end

`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;
   assign duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
   assign cmp_in  = PWM_BITS'(duty_sq >> PWM_BITS);
`else
   assign cmp_in  = duty;
`endif

   pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk      (clk),
      .rst      (rst),
      .cmp_in   (cmp_in),
      .force_on (state == ON),
      .pwm_out  (pwm_out)
   );

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with a 4-bit PWM and 3-clock duty step.
module tb_led_fade_pwm;
   import led_pkg::*;

   localparam int N  = 4;
   localparam int SC = 3;
`ifdef LED_FADE_GAMMA_EN
   localparam int EXP5 = (5 * 5) >> N;
   localparam int EXP8 = (8 * 8) >> N;
`else
   localparam int EXP5 = 5;
   localparam int EXP8 = 8;
`endif

   localparam int SIG_DUTY  = 0;
   localparam int SIG_BUSY  = 1;
   localparam int SIG_STATE = 2;
   localparam int SIG_PWM   = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         led_in;
   logic         pwm_out;
   logic [N-1:0] duty;
   logic         busy;

   led_fade_pwm #(
      .PWM_BITS    (N),
      .STEP_CYCLES (SC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .led_in  (led_in),
      .pwm_out (pwm_out),
      .duty    (duty),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      string tag;
      int    at;
      int    sig;
      int    val;
   } exp_t;
   exp_t sb[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] probe(input int sig);
      case (sig)
         SIG_DUTY:  return 32'(duty);
         SIG_BUSY:  return 32'(busy);
         SIG_STATE: return 32'(dut.state);
         default:   return 32'(pwm_out);
      endcase
   endfunction

   task automatic push(input string tag, input int at, input int sig, input int val);
      sb.push_back('{tag, at, sig, val});
   endtask

   // Scoreboard: compare each queued expectation on the cycle it is due.
   exp_t e;
   always begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         check_val(e.tag, probe(e.sig), 32'(e.val));
      end
   end

   // Within one period the compare is constant, so pwm_out may only rise at the wrap.
   logic watch = 1'b0;
   logic prev_pwm = 1'b0;
   int   bad_rise = 0;
   always @(negedge clk) begin
      if (watch && pwm_out && !prev_pwm && dut.u_pwm.pwm_cnt != 4'd1) bad_rise++;
      prev_pwm = pwm_out;
   end

   task automatic drain(input int limit);
      int k = 0;
      while (sb.size() > 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      check_val("sb_drain", sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_duty(input int v, input int limit);
      int k = 0;
      while (duty != N'(v) && k < limit) begin
         @(negedge clk);
         k++;
      end
      check_val($sformatf("reach_duty_%0d", v), duty, v);
   endtask

   task automatic freeze(input int cycles);
      repeat (cycles) begin
         led_in = ~led_in;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int hi;
      rst    = 1'b1;
      led_in = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_pwm", pwm_out, 0);
      check_val("rst_duty", duty, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_state", 32'(dut.state), 32'(OFF));
      rst = 1'b0;

      repeat (100) begin
         @(negedge clk);
         check_val("idle_pwm", pwm_out, 0);
         check_val("idle_duty", duty, 0);
         check_val("idle_busy", busy, 0);
      end

      // Full ramp up
      c = cyc;
      led_in = 1'b1;
      push("rise_state", c + 1, SIG_STATE, int'(RISE));
      push("rise_busy0", c + 1, SIG_BUSY, 0);
      push("rise_busy1", c + 2, SIG_BUSY, 1);
      push("rise_d0", c + 3, SIG_DUTY, 0);
      push("rise_d1", c + 4, SIG_DUTY, 1);
      push("rise_d14", c + 43, SIG_DUTY, 14);
      push("rise_late", c + 45, SIG_STATE, int'(RISE));
      push("on_duty", c + 46, SIG_DUTY, 15);
      push("on_state", c + 46, SIG_STATE, int'(ON));
      push("on_busy1", c + 46, SIG_BUSY, 1);
      push("on_busy0", c + 47, SIG_BUSY, 0);
      drain(60);
      hi = 0;
      repeat (32) begin
         @(negedge clk);
         hi += int'(pwm_out);
      end
      check_val("on_pwm_high", hi, 32);

      // Full ramp down
      c = cyc;
      led_in = 1'b0;
      push("fall_state", c + 1, SIG_STATE, int'(FALL));
      push("fall_d15", c + 1, SIG_DUTY, 15);
      push("fall_d14", c + 4, SIG_DUTY, 14);
      push("fall_d1", c + 45, SIG_DUTY, 1);
      push("fall_late", c + 45, SIG_STATE, int'(FALL));
      push("off_duty", c + 46, SIG_DUTY, 0);
      push("off_state", c + 46, SIG_STATE, int'(OFF));
      push("off_busy0", c + 47, SIG_BUSY, 0);
      drain(60);
      repeat (20) @(negedge clk);
      hi = 0;
      repeat (32) begin
         @(negedge clk);
         hi += int'(pwm_out);
      end
      check_val("off_pwm_high", hi, 0);

      // Reversal mid-ramp at duty 7
      watch  = 1'b1;
      led_in = 1'b1;
      wait_duty(7, 40);
      c = cyc;
      led_in = 1'b0;
      push("rev_state", c + 1, SIG_STATE, int'(FALL));
      push("rev_d7", c + 1, SIG_DUTY, 7);
      push("rev_d6", c + 4, SIG_DUTY, 6);
      push("rev_d1", c + 21, SIG_DUTY, 1);
      push("rev_off_d", c + 22, SIG_DUTY, 0);
      push("rev_off_s", c + 22, SIG_STATE, int'(OFF));
      drain(40);
      watch = 1'b0;
      check_val("pwm_rise_at_wrap", bad_rise, 0);

      // Reversal on the same clock as a step strobe
      repeat (4) @(negedge clk);
      led_in = 1'b1;
      repeat (6) @(negedge clk);
      c = cyc;
      led_in = 1'b0;
      push("coin_state", c + 1, SIG_STATE, int'(FALL));
      push("coin_duty", c + 1, SIG_DUTY, 1);
      push("coin_d0", c + 4, SIG_DUTY, 0);
      push("coin_off", c + 4, SIG_STATE, int'(OFF));
      drain(20);

      // Hold duty at 5 by reversing every clock, then measure high time
      led_in = 1'b1;
      wait_duty(5, 40);
      freeze(40);
      hi = 0;
      repeat (16) begin
         led_in = ~led_in;
         @(negedge clk);
         hi += int'(pwm_out);
      end
      check_val("pwm_high_d5", hi, EXP5);
      check_val("cmp_d5", dut.u_pwm.cmp, EXP5);
      check_val("frozen_d5", duty, 5);

      // Compare value at duty 8
      led_in = 1'b1;
      @(negedge clk);
      wait_duty(8, 40);
      freeze(40);
      check_val("cmp_d8", dut.u_pwm.cmp, EXP8);
      check_val("frozen_d8", duty, 8);

      // Asynchronous reset mid-ramp at duty 9
      led_in = 1'b1;
      @(negedge clk);
      wait_duty(9, 20);
      #2 rst = 1'b1;
      #1;
      check_val("arst_pwm", pwm_out, 0);
      check_val("arst_duty", duty, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_state", 32'(dut.state), 32'(OFF));
      check_val("arst_step", dut.step_cnt, 0);
      check_val("arst_pwmcnt", dut.u_pwm.pwm_cnt, 0);
      check_val("arst_cmp", dut.u_pwm.cmp, 0);
      repeat (3) @(negedge clk);
      check_val("rst_hold_state", 32'(dut.state), 32'(OFF));
      rst = 1'b0;
      c = cyc;
      push("post_rst_state", c + 1, SIG_STATE, int'(RISE));
      push("post_rst_d1", c + 4, SIG_DUTY, 1);
      drain(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
